// File: rtl/seg_anim_sequencer.sv
// Debounced six-button controller driving one seven-segment digit from four animations.
// Optional dp heartbeat on every frame tick: define SEG_DP_HEARTBEAT_EN.
module seg_anim_sequencer #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int BASE_DIV        = 100000,
    parameter int SPEED_LEVELS    = 8,
    parameter int COMMON_ANODE    = 0,
    localparam int SPEED_W        = $clog2(SPEED_LEVELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         btn_i,
    output logic [7:0]         seg_o,
    output logic [1:0]         anim_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic               tick_o,
    output logic               running_o
);

    localparam int     DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam longint MAX_RELOAD = longint'(BASE_DIV) << (SPEED_LEVELS - 1);
    localparam int     DIV_W      = $clog2(MAX_RELOAD + 1);

    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(SPEED_LEVELS - 1);
    localparam logic [7:0]         SEG_XOR   = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;

    // ---------------- synchronise and debounce ----------------
    logic [5:0]      sync1, sync2, stable, stable_q;
    logic [DB_W-1:0] db_cnt [6];
    logic [5:0]      press;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 6'd0;
            sync2    <= 6'd0;
            stable   <= 6'd0;
            stable_q <= 6'd0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= btn_i;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    stable[i] <= ~stable[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Only rising stable edges are events; releases are ignored.
    assign press = stable & ~stable_q;

    // ---------------- control decode ----------------
    logic [1:0]         anim_q;
    logic [SPEED_W-1:0] speed_q;
    logic               running_q;
    logic               dir_q;
    logic [3:0]         frame_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_last;
    logic               tick_q;
    logic [7:0]         seg_q;

    logic ani_inc, ani_dec, ani_chg;
    logic spd_up, spd_dn, spd_chg;
    logic tick;

    assign ani_inc = press[0] & ~press[1];
    assign ani_dec = press[1] & ~press[0];
    assign ani_chg = ani_inc | ani_dec;

    // A saturated press is not a change, so it neither clears the divider nor blocks a tick.
    assign spd_up  = press[2] & ~press[3] & (speed_q != SPEED_MAX);
    assign spd_dn  = press[3] & ~press[2] & (speed_q != '0);
    assign spd_chg = spd_up | spd_dn;

    assign div_last = (DIV_W'(BASE_DIV) << (SPEED_MAX - speed_q)) - DIV_W'(1);
    assign tick     = running_q & ~ani_chg & ~spd_chg & (div_q == div_last);

    // ---------------- animation, speed, run state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            anim_q    <= 2'd0;
            speed_q   <= '0;
            running_q <= 1'b1;
            dir_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            if (ani_inc)      anim_q <= anim_q + 2'd1;
            else if (ani_dec) anim_q <= anim_q - 2'd1;
            if (spd_up)       speed_q <= speed_q + SPEED_W'(1);
            else if (spd_dn)  speed_q <= speed_q - SPEED_W'(1);
            if (press[4])     running_q <= ~running_q;
            if (press[5])     dir_q <= ~dir_q;
            tick_q <= tick;
        end
    end

    // ---------------- tick divider ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (ani_chg || spd_chg) begin
            div_q <= '0;
        end else if (running_q) begin
            if (div_q == div_last) div_q <= '0;
            else                   div_q <= div_q + DIV_W'(1);
        end
    end

    // ---------------- frame counter ----------------
    logic [3:0] frame_last;

    always_comb begin
        frame_last = 4'd1;
        case (anim_q)
            2'd0:    frame_last = 4'd5;
            2'd1:    frame_last = 4'd7;
            2'd2:    frame_last = 4'd15;
            default: frame_last = 4'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= 4'd0;
        end else if (ani_chg) begin
            frame_q <= 4'd0;
        end else if (tick) begin
            if (dir_q) frame_q <= (frame_q == 4'd0) ? frame_last : frame_q - 4'd1;
            else       frame_q <= (frame_q == frame_last) ? 4'd0 : frame_q + 4'd1;
        end
    end

    // ---------------- frame tables (gfedcba) ----------------
    logic [6:0] pattern;

    always_comb begin
        pattern = 7'h00;
        case (anim_q)
            2'd0: begin
                case (frame_q)
                    4'd0:    pattern = 7'h01;
                    4'd1:    pattern = 7'h02;
                    4'd2:    pattern = 7'h04;
                    4'd3:    pattern = 7'h08;
                    4'd4:    pattern = 7'h10;
                    4'd5:    pattern = 7'h20;
                    default: pattern = 7'h00;
                endcase
            end
            2'd1: begin
                case (frame_q)
                    4'd0:    pattern = 7'h01;
                    4'd1:    pattern = 7'h02;
                    4'd2:    pattern = 7'h40;
                    4'd3:    pattern = 7'h10;
                    4'd4:    pattern = 7'h08;
                    4'd5:    pattern = 7'h04;
                    4'd6:    pattern = 7'h40;
                    4'd7:    pattern = 7'h20;
                    default: pattern = 7'h00;
                endcase
            end
            2'd2: begin
                case (frame_q)
                    4'd0:    pattern = 7'h3F;
                    4'd1:    pattern = 7'h06;
                    4'd2:    pattern = 7'h5B;
                    4'd3:    pattern = 7'h4F;
                    4'd4:    pattern = 7'h66;
                    4'd5:    pattern = 7'h6D;
                    4'd6:    pattern = 7'h7D;
                    4'd7:    pattern = 7'h07;
                    4'd8:    pattern = 7'h7F;
                    4'd9:    pattern = 7'h6F;
                    4'd10:   pattern = 7'h77;
                    4'd11:   pattern = 7'h7C;
                    4'd12:   pattern = 7'h39;
                    4'd13:   pattern = 7'h5E;
                    4'd14:   pattern = 7'h79;
                    default: pattern = 7'h71;
                endcase
            end
            default: pattern = (frame_q == 4'd0) ? 7'h7F : 7'h00;
        endcase
    end

    // ---------------- decimal point ----------------
    logic dp_bit;

`ifdef SEG_DP_HEARTBEAT_EN
    logic dp_q;

    always_ff @(posedge clk) begin
        if (rst)          dp_q <= 1'b0;
        else if (ani_chg) dp_q <= 1'b0;
        else if (tick)    dp_q <= ~dp_q;
    end

    assign dp_bit = dp_q;
`else
    assign dp_bit = 1'b0;
`endif

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) seg_q <= 8'h01 ^ SEG_XOR;
        else     seg_q <= {dp_bit, pattern} ^ SEG_XOR;
    end

    assign seg_o     = seg_q;
    assign anim_o    = anim_q;
    assign speed_o   = speed_q;
    assign tick_o    = tick_q;
    assign running_o = running_q;

endmodule

// File: tb/tb_seg_anim_sequencer.sv
// Randomised bench for seg_anim_sequencer: an event-level reference model fills an
// expected queue every cycle and a negedge monitor compares it against the outputs.
`timescale 1ns/1ps
module tb_seg_anim_sequencer;

    localparam int D      = 4;
    localparam int BASE   = 10;
    localparam int LEVELS = 4;
    localparam int CA     = 0;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btn = 6'd0;
    logic [7:0] seg;
    logic [1:0] anim;
    logic [1:0] speed;
    logic       tick;
    logic       running;

    always #5 clk = ~clk;

    seg_anim_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .BASE_DIV       (BASE),
        .SPEED_LEVELS   (LEVELS),
        .COMMON_ANODE   (CA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn),
        .seg_o    (seg),
        .anim_o   (anim),
        .speed_o  (speed),
        .tick_o   (tick),
        .running_o(running)
    );

    // ---------------- reference model ----------------
    logic [7:0] t_ring  [6]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    logic [7:0] t_fig8  [8]  = '{8'h01, 8'h02, 8'h40, 8'h10, 8'h08, 8'h04, 8'h40, 8'h20};
    logic [7:0] t_hex   [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0] t_blink [2]  = '{8'h7F, 8'h00};
    int         anim_len [4] = '{6, 8, 16, 2};

    logic [13:0] exp_q [$];
    logic [5:0]  ev_at [int];

    int   cyc = 0;
    bit   started = 0;
    int   m_anim, m_speed, m_frame, m_div, m_dp;
    bit   m_run, m_rev, m_tick;
    logic [7:0] m_seg;

    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 0;

    function automatic int period_of(input int s);
        return BASE * (1 << (LEVELS - 1 - s));
    endfunction

    function automatic logic [7:0] seg_of(input int a, input int f, input int dp);
        logic [7:0] p;
        case (a)
            0:       p = t_ring[f];
            1:       p = t_fig8[f];
            2:       p = t_hex[f];
            default: p = t_blink[f];
        endcase
`ifdef SEG_DP_HEARTBEAT_EN
        p[7] = dp[0];
`else
        p[7] = 1'b0 & dp[0];
`endif
        return p ^ ((CA != 0) ? 8'hFF : 8'h00);
    endfunction

    always @(posedge clk) begin
        logic [5:0] ev;
        int a_step, s_step, len;
        logic [7:0] new_seg;
        bit hit;
        #1;
        cyc++;
        if (rst) begin
            m_anim = 0; m_speed = 0; m_frame = 0; m_div = 0; m_dp = 0;
            m_run = 1; m_rev = 0; m_tick = 0;
            m_seg = seg_of(0, 0, 0);
            started = 1;
        end else if (started) begin
            ev = ev_at.exists(cyc) ? ev_at[cyc] : 6'd0;
            new_seg = seg_of(m_anim, m_frame, m_dp);
            a_step = 0;
            if (ev[0] && !ev[1])      a_step = 1;
            else if (ev[1] && !ev[0]) a_step = 3;
            s_step = 0;
            if (ev[2] && !ev[3] && m_speed < LEVELS - 1) s_step = 1;
            else if (ev[3] && !ev[2] && m_speed > 0)     s_step = -1;
            hit = m_run && a_step == 0 && s_step == 0 && m_div == period_of(m_speed) - 1;
            if (a_step != 0) begin
                m_anim = (m_anim + a_step) % 4;
                m_frame = 0; m_div = 0; m_dp = 0;
            end else begin
                if (s_step != 0) m_div = 0;
                else if (m_run)  m_div = (m_div + 1) % period_of(m_speed);
                if (hit) begin
                    len = anim_len[m_anim];
                    m_frame = m_rev ? (m_frame + len - 1) % len : (m_frame + 1) % len;
                    m_dp = m_dp ^ 1;
                end
            end
            m_speed = m_speed + s_step;
            if (ev[4]) m_run = !m_run;
            if (ev[5]) m_rev = !m_rev;
            m_tick = hit;
            m_seg  = new_seg;
        end
        if (started)
            exp_q.push_back({m_seg, 2'(m_anim), 2'(m_speed), m_tick, m_run});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [13:0] exp_v, got_v;
        if (exp_q.size() > 0 && !done) begin
            exp_v = exp_q.pop_front();
            got_v = {seg, anim, speed, tick, running};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d got seg=%h anim=%0d speed=%0d tick=%b run=%b expected seg=%h anim=%0d speed=%0d tick=%b run=%b",
                         cyc, got_v[13:6], got_v[5:4], got_v[3:2], got_v[1], got_v[0],
                         exp_v[13:6], exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic schedule(input logic [5:0] mask);
        int at;
        at = cyc + D + 3;
        if (ev_at.exists(at)) ev_at[at] = ev_at[at] | mask;
        else                  ev_at[at] = mask;
    endtask

    task automatic press(input logic [5:0] mask, input int hold, input int gap);
        if (gap < D + 2) gap = D + 2;
        btn = mask;
        if (hold >= D) schedule(mask);
        repeat (hold) @(negedge clk);
        btn = 6'd0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic press_on_terminal(input logic [5:0] mask);
        for (int i = 0; i < 400; i++) begin
            if (m_run && ((m_div + D + 2) % period_of(m_speed)) == period_of(m_speed) - 1) break;
            @(negedge clk);
        end
        press(mask, D + 1, D + 20);
    endtask

    task automatic reset_with_held(input logic [5:0] mask);
        rst = 1'b1;
        btn = mask;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        schedule(mask);
        repeat (D + 5) @(negedge clk);
        btn = 6'd0;
        repeat (D + 4) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);                   // free-running ring chase

        press(6'b000001, 3, 20);                         // glitch: rejected
        press(6'b000001, 10, 200);                       // anim 1
        press(6'b000010, 6, 20);                         // back to anim 0
        press(6'b000010, 6, 200);                        // anim 3 blink
        press(6'b000011, 6, 40);                         // both: no change

        repeat (5) press(6'b000100, D, 40);              // speed saturates at 3
        repeat (5) press(6'b001000, D + 2, 170);         // back to 0
        press_on_terminal(6'b000100);
        press_on_terminal(6'b001000);
        press_on_terminal(6'b000001);

        while (m_anim != 2) press(6'b000001, D + 1, 20);
        press(6'b100000, D + 1, 320);                    // reverse hex count
        press(6'b010000, D + 1, 500);                    // paused
        press(6'b010000, D + 1, 200);                    // resume

        for (int i = 0; i < 90; i++) begin
            k = $urandom_range(0, 11);
            case (k)
                0, 1, 2, 3, 4, 5: press(6'(1 << k), $urandom_range(D, D + 6), $urandom_range(D + 2, 120));
                6:  press(6'(1 << $urandom_range(0, 5)), $urandom_range(1, D - 1), $urandom_range(D + 2, 30));
                7:  press(6'b000011, D + 1, $urandom_range(D + 2, 60));
                8:  press_on_terminal(6'(1 << $urandom_range(0, 3)));
                9:  press(6'b001100, D + 1, $urandom_range(D + 2, 60));
                default: repeat ($urandom_range(50, 300)) @(negedge clk);
            endcase
        end

        // Bring state to anim 1, speed 2, paused, reverse, then reset with a held button.
        for (int i = 0; i < 4 && m_anim != 1; i++) press(6'b000001, D + 1, 20);
        for (int i = 0; i < 4 && m_speed < 2; i++) press(6'b000100, D + 1, 20);
        for (int i = 0; i < 4 && m_speed > 2; i++) press(6'b001000, D + 1, 20);
        if (m_run) press(6'b010000, D + 1, 20);
        if (!m_rev) press(6'b100000, D + 1, 20);
        repeat (50) @(negedge clk);
        reset_with_held(6'b000001);
        repeat (300) @(negedge clk);

        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        if (!done) begin
            done = 1;
            miscompares++;
            $display("FAIL watchdog cyc=%0d got no end of stimulus, expected finish before 5 ms", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

endmodule
